// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle core: FSM states, opcodes, functs and ALU controls.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_NONE  = 2'b11
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU_ANDN/ALU_ORN are implemented by the ALU but never issued by this controller
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
           alu_control, reg_write, reg_dst, mem_to_reg, illegal_op
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
           alu_control, reg_write, reg_dst, mem_to_reg, illegal_op
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps alu_op + funct to the ALU control code; funct_valid flags a supported R-type funct.
module alu_decoder
  import cpu_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  logic [2:0] funct_ctl;

  always_comb begin
    funct_valid = 1'b1;
    funct_ctl   = ALU_AND;
    case (funct)
      F_ADD:   funct_ctl = ALU_ADD;
      F_SUB:   funct_ctl = ALU_SUB;
      F_AND:   funct_ctl = ALU_AND;
      F_OR:    funct_ctl = ALU_OR;
      F_SLT:   funct_ctl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_ctl;
      default:     alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS-subset core with req/ready memory stalls.
//   state      | meaning
//   S_FETCH    | read instruction at PC, PC+4 on completion
//   S_DECODE   | precompute branch target, dispatch on opcode
//   S_MEMADR   | base + imm for lw/sw
//   S_MEMREAD  | load access, holds until mem_ready
//   S_MEMWB    | load data -> rt
//   S_MEMWRITE | store access, holds until mem_ready
//   S_EXECUTE  | R-type ALU op
//   S_ALUWB    | ALU result -> rd
//   S_BRANCH   | compare, take target when zero
//   S_ADDIEX   | rs + imm
//   S_ADDIWB   | ALU result -> rt
//   S_JUMP     | PC <- jump target
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  state_t     state;
  alu_op_t    alu_op;
  logic [2:0] alu_ctl_raw;
  logic       funct_valid;
  logic       decode_illegal;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (bus.funct),
    .alu_control (alu_ctl_raw),
    .funct_valid (funct_valid)
  );

  always_comb begin
    case (bus.opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_illegal = 1'b0;
      OP_RTYPE:                            decode_illegal = ~funct_valid;
      default:                             decode_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      case (state)
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (decode_illegal) state <= S_FETCH;
          else begin
            case (bus.opcode)
              OP_LW, OP_SW: state <= S_MEMADR;
              OP_RTYPE:     state <= S_EXECUTE;
              OP_BEQ:       state <= S_BRANCH;
              OP_ADDI:      state <= S_ADDIEX;
              OP_J:         state <= S_JUMP;
              default:      state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR:   state <= (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
        S_EXECUTE:  state <= S_ALUWB;
        S_ADDIEX:   state <= S_ADDIWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_en      = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal_op = 1'b0;
    alu_op         = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_en     = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b  = 2'b11;
        bus.illegal_op = decode_illegal;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        alu_op        = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        alu_op        = ALUOP_SUB;
        bus.pc_src    = 2'b01;
        bus.pc_en     = bus.zero;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_ADDIWB:  bus.reg_write = 1'b1;
      S_JUMP: begin
        bus.pc_src = 2'b10;
        bus.pc_en  = 1'b1;
      end
      default: ;
    endcase
    // reset overrides the FETCH decode so no enable or select leaks out while held
    if (reset) begin
      bus.mem_req    = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_en      = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.illegal_op = 1'b0;
    end
  end

  assign bus.alu_control = reset ? 3'b000 : alu_ctl_raw;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller against a per-instruction step model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  } ctrl_t;

  typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_J, K_BADOP, K_BADFN} kind_t;

  logic  clk;
  logic  reset;
  int    checks;
  int    errors;
  ctrl_t expq[$];

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic ctrl_t sample();
    ctrl_t a;
    a.mem_req     = bus.mem_req;
    a.mem_write   = bus.mem_write;
    a.iord        = bus.iord;
    a.ir_write    = bus.ir_write;
    a.pc_en       = bus.pc_en;
    a.pc_src      = bus.pc_src;
    a.alu_src_a   = bus.alu_src_a;
    a.alu_src_b   = bus.alu_src_b;
    a.alu_control = bus.alu_control;
    a.reg_write   = bus.reg_write;
    a.reg_dst     = bus.reg_dst;
    a.mem_to_reg  = bus.mem_to_reg;
    a.illegal_op  = bus.illegal_op;
    return a;
  endfunction

  // every non-special step adds, so the ALU code defaults to add
  function automatic ctrl_t idle();
    ctrl_t e;
    e = '0;
    e.alu_control = 3'b010;
    return e;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic bit legal_funct(input logic [5:0] fn);
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
           fn == 6'b100101 || fn == 6'b101010;
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // monitor: compares one expected step per cycle, just after the falling edge
  initial begin
    ctrl_t e;
    ctrl_t a;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = sample();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ctrl t=%0t act=%h exp=%h", $time, a, e);
        end
      end
    end
  end

  task automatic noise();
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.zero      = 1'($urandom_range(0, 1));
  endtask

  task automatic cyc(input ctrl_t e);
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    ctrl_t a;
    a = sample();
    checks++;
    if (a !== ctrl_t'(0)) begin
      errors++;
      $display("FAIL %s act=%h exp=0", name, a);
    end
  endtask

  task automatic run_instr(input kind_t k, input logic [5:0] fn, input logic [5:0] badop,
                           input int fw, input int mw, input logic zb);
    ctrl_t e;
    bit    bad;
    case (k)
      K_LW:         bus.opcode = 6'b100011;
      K_SW:         bus.opcode = 6'b101011;
      K_R, K_BADFN: bus.opcode = 6'b000000;
      K_BEQ:        bus.opcode = 6'b000100;
      K_ADDI:       bus.opcode = 6'b001000;
      K_J:          bus.opcode = 6'b000010;
      default:      bus.opcode = badop;
    endcase
    bus.funct = fn;
    bad = (k == K_BADOP) || (k == K_BADFN);
    for (int i = 0; i <= fw; i++) begin
      noise();
      bus.mem_ready = (i == fw);
      e = idle();
      e.mem_req = 1'b1; e.alu_src_b = 2'b01;
      e.ir_write = (i == fw); e.pc_en = (i == fw);
      cyc(e);
    end
    noise();
    e = idle();
    e.alu_src_b = 2'b11; e.illegal_op = bad;
    cyc(e);
    if (bad) return;
    case (k)
      K_LW, K_SW: begin
        noise();
        e = idle(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        cyc(e);
        for (int i = 0; i <= mw; i++) begin
          noise();
          bus.mem_ready = (i == mw);
          e = idle(); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = (k == K_SW);
          cyc(e);
        end
        if (k == K_LW) begin
          noise();
          e = idle(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          cyc(e);
        end
      end
      K_R: begin
        noise();
        e = idle(); e.alu_src_a = 1'b1; e.alu_control = ref_alu(fn);
        cyc(e);
        noise();
        e = idle(); e.reg_write = 1'b1; e.reg_dst = 1'b1;
        cyc(e);
      end
      K_BEQ: begin
        noise();
        bus.zero = zb;
        e = idle(); e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.pc_en = zb;
        cyc(e);
      end
      K_ADDI: begin
        noise();
        e = idle(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        cyc(e);
        noise();
        e = idle(); e.reg_write = 1'b1;
        cyc(e);
      end
      default: begin
        noise();
        e = idle(); e.pc_src = 2'b10; e.pc_en = 1'b1;
        cyc(e);
      end
    endcase
  endtask

  initial begin
    kind_t       k;
    logic [5:0]  fn;
    logic [5:0]  op;
    logic [5:0]  good_fn [5];
    ctrl_t       e;
    checks = 0;
    errors = 0;
    good_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b1;
    bus.opcode = 6'b0; bus.funct = 6'b0; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    #3;
    check_zero("reset_init");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_instr(K_LW,    6'b000000, 6'b0, 3, 2, 1'b0);
    run_instr(K_R,     6'b101010, 6'b0, 0, 0, 1'b0);
    run_instr(K_R,     6'b100010, 6'b0, 1, 0, 1'b0);
    run_instr(K_BEQ,   6'b000000, 6'b0, 0, 0, 1'b1);
    run_instr(K_BEQ,   6'b000000, 6'b0, 0, 0, 1'b0);
    run_instr(K_SW,    6'b000000, 6'b0, 0, 0, 1'b0);
    run_instr(K_BADOP, 6'b100000, 6'b111111, 0, 0, 1'b0);
    run_instr(K_BADFN, 6'b000001, 6'b0, 0, 0, 1'b0);
    run_instr(K_ADDI,  6'b000000, 6'b0, 2, 0, 1'b0);
    run_instr(K_J,     6'b000000, 6'b0, 0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      k  = kind_t'($urandom_range(0, 7));
      fn = 6'($urandom_range(0, 63));
      op = 6'($urandom_range(0, 63));
      if (k == K_R) fn = good_fn[$urandom_range(0, 4)];
      while (k == K_BADFN && legal_funct(fn)) fn = 6'($urandom_range(0, 63));
      while (legal_op(op)) op = 6'($urandom_range(0, 63));
      run_instr(k, fn, op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // abort an R-type in S_EXECUTE with an asynchronous reset pulse
    bus.opcode = 6'b000000; bus.funct = 6'b100000;
    noise(); bus.mem_ready = 1'b1;
    e = idle(); e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_en = 1'b1;
    cyc(e);
    noise();
    e = idle(); e.alu_src_b = 2'b11;
    cyc(e);
    bus.mem_ready = 1'b1; bus.zero = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check_zero("reset_mid_execute");
    @(negedge clk);
    check_zero("reset_held");
    reset = 1'b0;
    run_instr(K_ADDI, 6'b000000, 6'b0, 1, 0, 1'b0);

    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle CPU core; it is the producer side of the ALU's 3-bit alu_control interface and of every datapath enable.
- A Moore FSM sequences fetch, decode, execute, memory and writeback for a MIPS-subset ISA: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.
- An embedded ALU decoder turns alu_op plus funct into alu_control.
- Memory accesses use a req/ready handshake, so the FSM stalls on slow memory.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a write
- iord  out  1  address mux select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load the instruction register
- pc_en  out  1  PC load enable
- pc_src  out  2  PC mux select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_control  out  3  ALU operation code
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = data register
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct

Behaviour:
- Reset (asynchronous, active-high) forces the state to S_FETCH immediately.
- Outputs are a combinational function of state, plus mem_ready, zero and funct where stated. While reset is asserted, all enables are 0 and every select is 0.
- alu_op per state: 00 = add, 01 = sub, 10 = decode by funct.
- alu_control mapping:
  - alu_op 00 -> 010; alu_op 01 -> 110.
  - alu_op 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct, or alu_op 11 -> 000.
- Unlisted outputs are 0 in every state. alu_src_a, alu_src_b and alu_op are 0 unless stated.
- S_FETCH: mem_req = 1, iord = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
  - ir_write = pc_en = mem_ready.
  - Stays in S_FETCH until mem_ready, then goes to S_DECODE.
- S_DECODE: alu_src_b = 11, alu_op = 00 (precomputes the branch target). Next state by opcode:
  - 100011 or 101011 -> S_MEMADR
  - 000000 -> S_EXECUTE
  - 000100 -> S_BRANCH
  - 001000 -> S_ADDIEX
  - 000010 -> S_JUMP
  - Any other opcode: illegal_op = 1, return to S_FETCH.
  - Opcode 000000 with an unsupported funct: illegal_op = 1, return to S_FETCH.
- S_MEMADR: alu_src_a = 1, alu_src_b = 10. Next is S_MEMREAD for lw, S_MEMWRITE for sw.
- S_MEMREAD: mem_req = 1, iord = 1. Goes to S_MEMWB on mem_ready, else holds.
- S_MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next is S_FETCH.
- S_MEMWRITE: mem_req = 1, mem_write = 1, iord = 1. Goes to S_FETCH on mem_ready, else holds.
- S_EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next is S_ALUWB.
- S_ALUWB: reg_write = 1, reg_dst = 1. Next is S_FETCH.
- S_BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, pc_en = zero. Next is S_FETCH.
- S_ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next is S_ADDIWB.
- S_ADDIWB: reg_write = 1, reg_dst = 0. Next is S_FETCH.
- S_JUMP: pc_src = 10, pc_en = 1. Next is S_FETCH.
- Stall and handshake rules:
  - mem_req, mem_write and iord are held stable for the whole wait.
  - mem_ready outside a memory state is ignored.
  - mem_ready in the same cycle as mem_req completes the access in that cycle (zero-wait memory is legal).
- Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Reset mid-instruction aborts it. No write enable may be asserted in the cycle reset is high.
- The state register uses an enum. An unreachable encoding returns to S_FETCH.

Decomposition:
- cpu_pkg holds:
  - state_t enum (12 states)
  - opcode constants OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_ADDI/OP_J
  - funct constants F_ADD/F_SUB/F_AND/F_OR/F_SLT
  - alu_control constants ALU_AND/ALU_OR/ALU_ADD/ALU_ANDN/ALU_ORN/ALU_SUB/ALU_SLT
  - alu_op_t
- The ALU encodings are shared with the ALU.
- One sub-module: alu_decoder. It is combinational, maps alu_op + funct to alu_control plus funct_valid, and is instantiated once.

Test Plan:
- Reset pulse mid-S_EXECUTE -> state is S_FETCH asynchronously, with reg_write = 0 and pc_en = 0 during reset.
- lw (opcode 100011), mem_ready held low 3 cycles in S_FETCH and 2 cycles in S_MEMREAD -> 10 cycles total; exactly one ir_write pulse and one reg_write pulse with mem_to_reg = 1.
- R-type funct 101010 -> alu_control = 111 in S_EXECUTE; S_ALUWB has reg_dst = 1. R-type funct 100010 -> alu_control = 110.
- beq with zero = 1 -> pc_en = 1, pc_src = 01, alu_control = 110. With zero = 0 -> pc_en = 0. Both return to S_FETCH after 3 cycles.
- sw with zero-wait memory -> S_MEMWRITE lasts 1 cycle with mem_write = 1, iord = 1; reg_write is never asserted.
- Opcode 111111 and R-type funct 000001 -> illegal_op pulses for 1 cycle in S_DECODE, no write enable fires, next state is S_FETCH.
